regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-read-port register file for the MIPS datapath; the next generation of the 2R1W file.
//   Adds N read ports, a byte-masked write, optional same-cycle write-to-read bypass and an optional hard-wired zero register.
//   Adds a hardware clear sequencer: after reset every register is zeroed, one entry per cycle, and `ready` then asserts.
//   Sits between decode (read addresses) and writeback (write port); the control FSM stalls on !ready.
// PARAMETERS
//   WIDTH     32  data width in bits; must be a multiple of 8
//   ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//   NRD       2   number of read ports, 1..8
//   ZERO_REG  1   1: entry 0 reads as 0 and writes to it are dropped; 0: entry 0 is an ordinary register
//   BYPASS    1   1: a read of the entry being written this cycle returns the new (merged) data; 0: returns the old data
// PORTS
//   clk    in   1             clock; all state changes on the rising edge
//   reset  in   1             synchronous, active-high reset
//   we     in   1             write enable
//   wbe    in   WIDTH/8       byte enables for the write; bit i covers wd[8i+7:8i]
//   wa     in   ADDR_W        write address
//   wd     in   WIDTH         write data
//   ra     in   NRD*ADDR_W    read addresses; port p = ra[p*ADDR_W +: ADDR_W]
//   rd     out  NRD*WIDTH     read data, combinational; port p = rd[p*WIDTH +: WIDTH]
//   ready  out  1             1 = clear finished, file usable
// BEHAVIOUR
//   States: CLEAR, RUN. An edge with reset=1 sets state=CLEAR and cnt=0, regardless of the current state.
//   CLEAR: each edge with reset=0 writes rf[cnt]<=0 and increments cnt. The edge that clears cnt==DEPTH-1 moves the state to RUN.
//   Latency: ready rises exactly DEPTH edges after the first edge with reset=0 (32 for the defaults).
//   Reset during CLEAR restarts the sequence at cnt=0. Reset during RUN re-enters CLEAR; all contents are lost.
//   Outputs while reset=1 or state=CLEAR: ready=0 and every rd port=0. The we/wa/wd/wbe inputs are ignored.
//   RUN: ready=1. On an edge with we=1, for each i with wbe[i]=1: rf[wa][8i+7:8i] <= wd[8i+7:8i].
//     Bytes whose wbe bit is 0 keep their value. we=1 with wbe=0 changes nothing.
//   ZERO_REG=1: a write with wa=0 is dropped; ra=0 returns 0 on every port. This holds even with a matching bypass.
//   Reads: rd_p = rf[ra_p], combinational and zero-latency; all NRD ports are fully independent, including equal addresses.
//   BYPASS=1, RUN, we=1, ra_p==wa, and wa is not a dropped zero write:
//     rd_p = per-byte merge: wd where wbe=1, rf[wa] where wbe=0.
//   BYPASS=0: rd_p shows the old rf[ra_p] until the edge, then the new value.
//   Only one write port exists, so there are no write-write conflicts. cnt is ADDR_W bits wide; DEPTH-1 is the last entry and cnt never wraps.
//   No X on rd for any in-range address after ready=1; every address is in range by construction.
// TESTING
//   1 Hold reset 3 cycles, release; sample ready each edge -> ready=0 for 32 edges, 1 on edge 32; all 32 entries read 0 on both ports.
//   2 RUN: write wa=5, wd=32'hDEADBEEF, wbe=4'hF; next cycle write wa=5, wd=32'h11223344, wbe=4'b0101
//     -> ra=5 reads 32'hDE22BE44.
//   3 BYPASS=1: in the same cycle as the write wa=7, wd=32'hCAFEF00D, wbe=4'hF, drive ra0=7, ra1=7
//     -> both ports show 32'hCAFEF00D before the edge. Repeat with BYPASS=0 -> old value (0) before the edge.
//   4 ZERO_REG=1: write wa=0, wd=32'hFFFFFFFF, with ra0=0 -> rd0=0 in that cycle and after the edge.
//     With ZERO_REG=0 -> 32'hFFFFFFFF after the edge.
//   5 Assert reset for 1 cycle at cnt=10 of the clear -> ready rises 32 edges after release, not 22.
//     Writes issued during CLEAR leave every entry 0.
//   6 NRD=4 build: four distinct addresses {1,2,3,31} preloaded with 1,2,3,31 -> rd ports show 1,2,3,31 concurrently.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-masked write, optional write-to-read bypass,
// optional hard-wired zero entry and a post-reset clear sequencer that gates `ready`.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [WIDTH/8-1:0]      wbe,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic [NRD*ADDR_W-1:0]   ra,
    output logic [NRD*WIDTH-1:0]    rd,
    output logic                    ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = WIDTH / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    rf_q [DEPTH];
    logic [WIDTH-1:0]    rf_d [DEPTH];
    logic                run;
    logic                wr_drop;
    logic [WIDTH-1:0]    wr_merged;

    function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_v,
                                                    input logic [WIDTH-1:0] nxt_v,
                                                    input logic [NB-1:0]    be);
        logic [WIDTH-1:0] m;
        m = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) m[8*i +: 8] = nxt_v[8*i +: 8];
        end
        return m;
    endfunction

    assign run       = (state_q == RUN) && !reset;
    assign ready     = run;
    assign wr_drop   = (ZERO_REG != 0) && (wa == '0);
    assign wr_merged = byte_merge(rf_q[wa], wd, wbe);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rf_d    = rf_q;
        if (reset) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            rf_d[cnt_q] = '0;
            // Hold cnt on the last entry rather than wrapping to 0.
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (we && !wr_drop) begin
            rf_d[wa] = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rf_q    <= rf_d;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        assign a   = ra[p*ADDR_W +: ADDR_W];
        // wr_merged already reads rf_q[wa], which equals rf_q[a] on a hit.
        assign hit = (BYPASS != 0) && we && (a == wa) && !wr_drop;
        assign rd[p*WIDTH +: WIDTH] = (!run || ((ZERO_REG != 0) && (a == '0))) ? '0 :
                                      hit ? wr_merged : rf_q[a];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (bypass, zero reg) and a 4-port instance
// without bypass or zero reg, checked by vector tables, directed sequences and a random model.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         reset, we;
    logic [3:0]   wbe;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [9:0]   ra0;
    logic [19:0]  ra1;
    logic [63:0]  rd0;
    logic [127:0] rd1;
    logic         rdy0, rdy1;

    int total = 0;
    int bad   = 0;

    // Reference state: mem[0] = default build, mem[1] = 4-port build; clr_edges counts
    // reset-free edges since the last reset edge, the file is usable from 32 onward.
    logic [31:0] mem [2][32];
    int          clr_edges = 0;

    always #5 clk = ~clk;

    regfile_mp u0 (
        .clk(clk), .reset(reset), .we(we), .wbe(wbe), .wa(wa), .wd(wd),
        .ra(ra0), .rd(rd0), .ready(rdy0)
    );

    regfile_mp #(.NRD(4), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .we(we), .wbe(wbe), .wa(wa), .wd(wd),
        .ra(ra1), .rd(rd1), .ready(rdy1)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wbe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] b0;
        logic [31:0] b1;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = o;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = n[8*i +: 8];
        return m;
    endfunction

    function automatic logic [31:0] exp_rd(input int cfg, input logic [4:0] a);
        if (reset || clr_edges < 32) return 32'h0;
        if (cfg == 0 && a == 5'd0) return 32'h0;
        if (cfg == 0 && we && a == wa) return merge(mem[0][a], wd, wbe);
        return mem[cfg][a];
    endfunction

    task automatic model_step();
        if (reset) begin
            clr_edges = 0;
        end else if (clr_edges < 32) begin
            clr_edges++;
            if (clr_edges == 32)
                for (int c = 0; c < 2; c++) for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
        end else if (we) begin
            if (wa != 5'd0) mem[0][wa] = merge(mem[0][wa], wd, wbe);
            mem[1][wa] = merge(mem[1][wa], wd, wbe);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string nm);
        logic exp_rdy;
        exp_rdy = !reset && (clr_edges >= 32);
        chk({nm, " ready0"}, {31'd0, rdy0}, {31'd0, exp_rdy});
        chk({nm, " ready1"}, {31'd0, rdy1}, {31'd0, exp_rdy});
        for (int p = 0; p < 2; p++)
            chk($sformatf("%s u0 rd%0d ra=%0d", nm, p, ra0[p*5 +: 5]), rd0[p*32 +: 32],
                exp_rd(0, ra0[p*5 +: 5]));
        for (int p = 0; p < 4; p++)
            chk($sformatf("%s u1 rd%0d ra=%0d", nm, p, ra1[p*5 +: 5]), rd1[p*32 +: 32],
                exp_rd(1, ra1[p*5 +: 5]));
    endtask

    task automatic rand_write();
        we  = 1'b1;
        wbe = 4'($urandom);
        wa  = 5'($urandom);
        wd  = $urandom;
    endtask

    task automatic read_all_zero(input string nm);
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra0 = {5'(a), 5'(a)};
            ra1 = {5'(a), 5'(a), 5'(a), 5'(a)};
            #1;
            chk($sformatf("%s u0 a=%0d", nm, a), rd0[31:0], 32'h0);
            chk($sformatf("%s u0p1 a=%0d", nm, a), rd0[63:32], 32'h0);
            chk($sformatf("%s u1 a=%0d", nm, a), rd1[31:0], 32'h0);
            chk($sformatf("%s u1p3 a=%0d", nm, a), rd1[127:96], 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0] = '{1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 4'h5, 5'd5, 32'h11223344, 5'd5, 5'd6, 32'hDE22BE44, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b0, 4'hF, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
        tbl[3] = '{1'b1, 4'hF, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 4'hF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D};
        tbl[5] = '{1'b0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDE22BE44, 32'hFFFFFFFF, 32'hDE22BE44};
        tbl[6] = '{1'b1, 4'h0, 5'd5, 32'h0, 5'd5, 5'd7, 32'hDE22BE44, 32'hCAFEF00D, 32'hDE22BE44, 32'hCAFEF00D};
        tbl[7] = '{1'b0, 4'h0, 5'd0, 32'h0, 5'd5, 5'd3, 32'hDE22BE44, 32'h0, 32'hDE22BE44, 32'h0};

        reset = 1'b1; we = 1'b0; wbe = 4'h0; wa = 5'd0; wd = 32'h0; ra0 = '0; ra1 = '0;

        // Reset held 3 cycles, then the clear takes exactly 32 edges.
        repeat (3) tick();
        chk("reset ready0", {31'd0, rdy0}, 32'd0);
        chk("reset rd0", rd0[31:0], 32'h0);
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            ra0 = 10'($urandom);
            rand_write();
            #1;
            chk($sformatf("clear rd e=%0d", e), rd0[31:0], 32'h0);
            tick();
            chk($sformatf("ready0 edge %0d", e), {31'd0, rdy0}, {31'd0, (e == 32)});
            chk($sformatf("ready1 edge %0d", e), {31'd0, rdy1}, {31'd0, (e == 32)});
        end
        read_all_zero("post clear");

        // Byte merge, bypass on/off, zero register on/off.
        for (int i = 0; i < 8; i++) begin
            we = tbl[i].we; wbe = tbl[i].wbe; wa = tbl[i].wa; wd = tbl[i].wd;
            ra0 = {tbl[i].ra1, tbl[i].ra0};
            ra1 = {5'd0, 5'd0, tbl[i].ra1, tbl[i].ra0};
            #1;
            chk($sformatf("vec%0d u0 rd0", i), rd0[31:0], tbl[i].e0);
            chk($sformatf("vec%0d u0 rd1", i), rd0[63:32], tbl[i].e1);
            chk($sformatf("vec%0d u1 rd0", i), rd1[31:0], tbl[i].b0);
            chk($sformatf("vec%0d u1 rd1", i), rd1[63:32], tbl[i].b1);
            tick();
        end

        // Four independent ports read four distinct entries at once.
        we = 1'b1; wbe = 4'hF;
        foreach (ra1[i]) ;
        wa = 5'd1;  wd = 32'd1;  tick();
        wa = 5'd2;  wd = 32'd2;  tick();
        wa = 5'd3;  wd = 32'd3;  tick();
        wa = 5'd31; wd = 32'd31; tick();
        we = 1'b0;
        ra1 = {5'd31, 5'd3, 5'd2, 5'd1};
        ra0 = {5'd31, 5'd1};
        #1;
        chk("nrd4 p0", rd1[31:0], 32'd1);
        chk("nrd4 p1", rd1[63:32], 32'd2);
        chk("nrd4 p2", rd1[95:64], 32'd3);
        chk("nrd4 p3", rd1[127:96], 32'd31);
        chk("u0 p0 a1", rd0[31:0], 32'd1);
        chk("u0 p1 a31", rd0[63:32], 32'd31);

        // Reset at cnt=10 restarts the full 32-edge clear; writes meanwhile are ignored.
        reset = 1'b1; tick();
        reset = 1'b0;
        repeat (10) begin rand_write(); tick(); end
        reset = 1'b1; tick();
        reset = 1'b0;
        n = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            rand_write();
            tick();
            n++;
        end
        chk("restart latency", 32'(n), 32'd32);
        read_all_zero("restart clear");

        // Random traffic against the reference model, with occasional resets.
        for (int it = 0; it < 500; it++) begin
            reset = ($urandom_range(0, 149) == 0);
            we    = 1'($urandom);
            wbe   = 4'($urandom);
            wa    = 5'($urandom_range(0, 7));
            wd    = $urandom;
            for (int p = 0; p < 2; p++)
                ra0[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++)
                ra1[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            #1;
            check_model($sformatf("rand%0d", it));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
